lfsr_bank: RTL
==============

// Module: lfsr_bank
// PURPOSE
//  Multi-channel successor to the single 32-bit LFSR application unit. Holds NCH independent
//  Fibonacci LFSRs of WIDTH bits, each with its own polynomial, state, control and step-count
//  registers. Sits behind the AFU MMIO decoder: the AFU passes the write/read strobes, the dword
//  address, the data and the TID, and forwards the read response to c2.
//  Adds a counted-run mode, one-shot step auto-clear, a W1C done status and zero-lockup flags.
// PARAMETERS
//  WIDTH  32        LFSR/polynomial width, 2..64
//  NCH    4         channel count, 1..16
//  CNT_W  32        step-count register width, 1..64
//  BASE   16'h0010  dword address of channel 0; channel c occupies BASE+4c .. BASE+4c+3
// PORTS
//  clock     in   1          rising-edge clock
//  reset     in   1          asynchronous, active-low (0 = in reset)
//  wr_valid  in   1          MMIO write strobe, one cycle per write
//  rd_valid  in   1          MMIO read strobe, one cycle per read
//  addr      in   16         dword address
//  wdata     in   64         write data
//  rd_tid    in   9          read TID, captured with rd_valid
//  rsp_valid out  1          read response valid, single-cycle pulse
//  rsp_tid   out  9          echoed TID
//  rsp_data  out  64         read data, zero-extended
//  q_out     out  NCH*WIDTH  live LFSR states; channel c = q_out[c*WIDTH +: WIDTH]
//  running   out  NCH        1 = channel mode is not STOP
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert):
//   - all regs 0: poly, state, ctrl, count, done.
//   - rsp_valid=0, rsp_tid=0, rsp_data=0.
//  Address map:
//   - 16'h000C STATUS: read {zero[NCH-1:0] at [31:16], done[NCH-1:0] at [15:0]}.
//   - Writing STATUS clears done bits under a wdata[15:0] mask (write-1-to-clear).
//   - Per channel: +0 POLY, +1 DATA (state), +2 CTRL [1:0], +3 COUNT.
//   - Writes take the low bits of wdata. Unmapped reads return 0. Unmapped writes are ignored.
//  Step function:
//   - next = {Q[WIDTH-2:0], ^(Q & POLY)}.
//   - zero[c] is combinational (Q==0); the channel still steps and stays 0.
//  Modes (CTRL):
//   - 00 STOP: hold.
//   - 01 STEP: one step on the cycle after the write; CTRL then returns to 00.
//   - 10 CONT: step every cycle.
//   - 11 COUNTED: each cycle with COUNT>0 -> step, COUNT--.
//     When COUNT goes 1->0: CTRL->00 and done[c] set in the same edge.
//     Entering 11 with COUNT==0: no step; CTRL->00 and done[c] set on the next edge.
//  Write precedence within a channel (same cycle):
//   - A DATA write beats the step: the state loads wdata and no step occurs that cycle.
//   - A CTRL write beats the internal auto-clear and the count decrement.
//   - A COUNT write beats the decrement.
//   - A POLY write takes effect from the next step.
//  Done set vs STATUS clear in the same cycle: set wins.
//  Reads:
//   - Latency is 1: the cycle after rd_valid gives rsp_valid=1 with rsp_tid=rd_tid.
//   - A read in the same cycle as a write or step returns the pre-edge value.
//   - Back-to-back reads are accepted every cycle. No backpressure.
//  Reset asserted mid-run: everything clears immediately; there is no completion pulse.
// STRUCTURE
//  Package lfsr_bank_pkg:
//   - typedef enum logic[1:0] {STOP, STEP, CONT, COUNTED} lfsr_mode_e
//   - localparams OFF_POLY=0, OFF_DATA=1, OFF_CTRL=2, OFF_CNT=3, STATUS_ADDR=16'h000C
//  Sub-module lfsr_chan:
//   - one channel: its registers, mode FSM and step logic.
//   - generated NCH times.
//  Top level: address decode, status register and the read-response mux/register.
// TESTING
//  1. WIDTH=8: POLY=0xB8, DATA=0x80, CTRL=01
//     -> DATA=0x01 one cycle later; CTRL reads 00; running[0] pulses for 1 cycle.
//  2. Ch1: POLY=0xB8, DATA=0x01, COUNT=5, CTRL=11
//     -> exactly 5 steps; COUNT=0; CTRL=00; STATUS[1]=1.
//     -> Then write STATUS 0x0002 -> STATUS[1]=0.
//  3. Ch0 CONT, then a DATA write of 0x5A mid-run
//     -> state=0x5A that edge, stepping resumes the next cycle; other channels undisturbed.
//  4. rd_valid with tid 0x1A3 on ch2 DATA during CONT
//     -> rsp_valid the next cycle, rsp_tid=0x1A3, data = the pre-edge state.
//  5. COUNTED with COUNT=0 -> no step; CTRL=00 and done set one cycle later.
//     Then a STATUS clear in the same cycle as another done set -> bit stays 1.
//  6. Pull reset low asynchronously mid-CONT on all channels
//     -> all regs and outputs 0 before the next edge; read 0x0009 (unmapped) -> 0.

Source files
------------

// File: rtl/lfsr_bank_pkg.sv
// Shared definitions for the multi-channel LFSR bank.
//   lfsr_mode_e : per-channel CTRL[1:0] encoding, also the channel FSM state
//   OFF_*       : register offsets inside a channel's 4-dword window
//   STATUS_ADDR : dword address of the shared done/zero status register
//   MMIO_DW     : MMIO data width
//   TID_W       : read transaction id width
package lfsr_bank_pkg;

    typedef enum logic [1:0] {
        STOP    = 2'b00,
        STEP    = 2'b01,
        CONT    = 2'b10,
        COUNTED = 2'b11
    } lfsr_mode_e;

    localparam logic [1:0]  OFF_POLY    = 2'd0;
    localparam logic [1:0]  OFF_DATA    = 2'd1;
    localparam logic [1:0]  OFF_CTRL    = 2'd2;
    localparam logic [1:0]  OFF_CNT     = 2'd3;
    localparam logic [15:0] STATUS_ADDR = 16'h000C;

    localparam int MMIO_DW = 64;
    localparam int TID_W   = 9;

endpackage

// File: rtl/lfsr_bank_chan.sv
// One LFSR channel: POLY, DATA (state), CTRL (mode FSM) and COUNT registers
// plus the Fibonacci step logic.
// Ports:
//   clock, reset        : rising-edge clock, async active-low reset
//   wr_poly/data/ctrl/cnt : decoded single-cycle register write strobes
//   wdata               : MMIO write data, low bits are taken
//   poly, state, count  : register contents
//   mode                : current mode, i.e. the FSM state (also visible for debug)
//   zero                : state is all zeros (lock-up indication)
//   done_set            : the coming edge finishes a counted run or a
//                         zero-count COUNTED request
module lfsr_chan
    import lfsr_bank_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_poly,
    input  logic               wr_data,
    input  logic               wr_ctrl,
    input  logic               wr_cnt,
    input  logic [MMIO_DW-1:0] wdata,
    output logic [WIDTH-1:0]   poly,
    output logic [WIDTH-1:0]   state,
    output lfsr_mode_e         mode,
    output logic [CNT_W-1:0]   count,
    output logic               zero,
    output logic               done_set
);

    logic             step_req;
    logic             auto_stop;
    logic             dec_req;
    logic [WIDTH-1:0] next_state;

    // Upper write-data bits beyond WIDTH/CNT_W are intentionally dropped.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    // Shift left, new LSB is the parity of the tapped bits.
    assign next_state = {state[WIDTH-2:0], ^(state & poly)};
    assign zero       = (state == '0);

    always_comb begin
        step_req  = 1'b0;
        auto_stop = 1'b0;
        dec_req   = 1'b0;
        unique case (mode)
            STOP: begin
            end
            STEP: begin
                step_req  = 1'b1;
                auto_stop = 1'b1;
            end
            CONT: begin
                step_req = 1'b1;
            end
            COUNTED: begin
                if (count != '0) begin
                    step_req  = 1'b1;
                    dec_req   = 1'b1;
                    auto_stop = (count == CNT_W'(1));
                end else begin
                    // Started with nothing to do: finish without stepping.
                    auto_stop = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // A software CTRL write overrides the channel's own progress, so a
    // completion that coincides with it is not reported.
    assign done_set = (mode == COUNTED) && auto_stop && !wr_ctrl;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            poly  <= '0;
            state <= '0;
            mode  <= STOP;
            count <= '0;
        end else begin
            if (wr_poly) begin
                poly <= wdata[WIDTH-1:0];
            end

            if (wr_data) begin
                state <= wdata[WIDTH-1:0];
            end else if (step_req) begin
                state <= next_state;
            end

            if (wr_ctrl) begin
                mode <= lfsr_mode_e'(wdata[1:0]);
            end else if (auto_stop) begin
                mode <= STOP;
            end

            if (wr_cnt) begin
                count <= wdata[CNT_W-1:0];
            end else if (dec_req && !wr_ctrl) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/lfsr_bank.sv
// Bank of NCH independent Fibonacci LFSR channels behind an MMIO window.
// Channel c occupies dwords BASE+4c .. BASE+4c+3 (POLY, DATA, CTRL, COUNT);
// STATUS at 0x000C holds zero flags in [31:16] and W1C done flags in [15:0].
// Ports:
//   clock, reset          : rising-edge clock, async active-low reset
//   wr_valid, rd_valid    : MMIO write / read strobes
//   addr, wdata, rd_tid   : dword address, write data, read transaction id
//   rsp_valid/tid/data    : read response, one cycle after rd_valid
//   q_out                 : live LFSR states, channel c at [c*WIDTH +: WIDTH]
//   running               : per-channel "mode is not STOP"
//
// Handshake: wr_valid and rd_valid are one-cycle strobes that are always
// accepted (there is no ready); every accepted rd_valid yields exactly one
// rsp_valid pulse on the next cycle carrying the value seen before that edge.
module lfsr_bank
    import lfsr_bank_pkg::*;
#(
    parameter int          WIDTH = 32,
    parameter int          NCH   = 4,
    parameter int          CNT_W = 32,
    parameter logic [15:0] BASE  = 16'h0010
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_valid,
    input  logic                   rd_valid,
    input  logic [15:0]            addr,
    input  logic [MMIO_DW-1:0]     wdata,
    input  logic [TID_W-1:0]       rd_tid,
    output logic                   rsp_valid,
    output logic [TID_W-1:0]       rsp_tid,
    output logic [MMIO_DW-1:0]     rsp_data,
    output logic [NCH*WIDTH-1:0]   q_out,
    output logic [NCH-1:0]         running
);

    logic [WIDTH-1:0]   poly_a  [NCH];
    logic [WIDTH-1:0]   state_a [NCH];
    lfsr_mode_e         mode_a  [NCH];
    logic [CNT_W-1:0]   cnt_a   [NCH];
    logic [NCH-1:0]     zero;
    logic [NCH-1:0]     done_set;
    logic [NCH-1:0]     done;

    logic [15:0]        offset;
    logic [13:0]        chan_sel;
    logic [1:0]         reg_sel;
    logic               in_range;
    logic               status_wr;
    logic [NCH-1:0]     done_clr;
    logic [MMIO_DW-1:0] rd_word;

    // Channel window decode relative to BASE.
    assign offset   = addr - BASE;
    assign chan_sel = offset[15:2];
    assign reg_sel  = offset[1:0];
    assign in_range = (addr >= BASE) && ({2'b00, chan_sel} < 16'(NCH));

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        logic sel;
        assign sel = wr_valid && in_range && (chan_sel == 14'(c));

        lfsr_chan #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .wr_poly  (sel && (reg_sel == OFF_POLY)),
            .wr_data  (sel && (reg_sel == OFF_DATA)),
            .wr_ctrl  (sel && (reg_sel == OFF_CTRL)),
            .wr_cnt   (sel && (reg_sel == OFF_CNT)),
            .wdata    (wdata),
            .poly     (poly_a[c]),
            .state    (state_a[c]),
            .mode     (mode_a[c]),
            .count    (cnt_a[c]),
            .zero     (zero[c]),
            .done_set (done_set[c])
        );

        assign q_out[c*WIDTH +: WIDTH] = state_a[c];
        assign running[c]              = (mode_a[c] != STOP);
    end

    // Done flags: set by channel completion, cleared by write-1-to-clear;
    // a set in the same cycle as a clear wins.
    assign status_wr = wr_valid && (addr == STATUS_ADDR);
    assign done_clr  = status_wr ? wdata[NCH-1:0] : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done <= '0;
        end else begin
            done <= (done & ~done_clr) | done_set;
        end
    end

    // Read mux: combinational view of the pre-edge register contents.
    always_comb begin
        rd_word = '0;
        if (addr == STATUS_ADDR) begin
            rd_word[16 +: NCH] = zero;
            rd_word[0 +: NCH]  = done;
        end else if (in_range) begin
            for (int c = 0; c < NCH; c++) begin
                if (chan_sel == 14'(c)) begin
                    unique case (reg_sel)
                        OFF_POLY: rd_word = MMIO_DW'(poly_a[c]);
                        OFF_DATA: rd_word = MMIO_DW'(state_a[c]);
                        OFF_CTRL: rd_word = MMIO_DW'(mode_a[c]);
                        OFF_CNT:  rd_word = MMIO_DW'(cnt_a[c]);
                        default:  rd_word = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rd_valid;
            if (rd_valid) begin
                rsp_tid  <= rd_tid;
                rsp_data <= rd_word;
            end
        end
    end

endmodule
